// File: rtl/ascon_msg_loader.sv
// Upstream data stage for the ASCON core: collects 32-bit message words into
// 64-bit big-endian rate blocks, applies 0x80/zero padding and emits them over valid/ready.
module ascon_msg_loader #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_length,
  input  logic [LEN_W-1:0] length_in,
  input  logic             load_data_in,
  input  logic [31:0]      data_in,
  output logic             data_ready,
  output logic             blk_valid,
  output logic [63:0]      blk_data,
  output logic             blk_last,
  input  logic             blk_ready,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, PAD} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             widx_q, widx_d;
  logic [63:0]      buf_q, buf_d;
  logic             last_q, last_d;
  logic             padp_q, padp_d;
  logic             ovr_q, ovr_d;

  logic [2:0]       n;
  logic [31:0]      word;
  logic [LEN_W-1:0] rem_after;

  // Keep the first n bytes of the incoming word, put the pad byte right after them.
  always_comb begin
    n    = (rem_q >= LEN_W'(4)) ? 3'd4 : 3'(rem_q);
    word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < 32'(n))       word[31-8*i -: 8] = data_in[31-8*i -: 8];
      else if (i == 32'(n)) word[31-8*i -: 8] = 8'h80;
    end
    rem_after = rem_q - LEN_W'(n);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    widx_d  = widx_q;
    buf_d   = buf_q;
    last_d  = last_q;
    padp_d  = padp_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (load_length) begin
          rem_d   = length_in;
          widx_d  = 1'b0;
          buf_d   = '0;
          last_d  = 1'b0;
          padp_d  = 1'b0;
          ovr_d   = 1'b0;
          state_d = (length_in != '0) ? FILL : PAD;
        end
      end
      FILL: begin
        if (load_data_in) begin
          widx_d = ~widx_q;
          rem_d  = rem_after;
          if (!widx_q) begin
            buf_d[63:32] = word;
            if (rem_after == '0) begin
              last_d  = 1'b1;
              state_d = EMIT;
              if (n == 3'd4) buf_d[31:24] = 8'h80;
            end
          end else begin
            buf_d[31:0] = word;
            state_d     = EMIT;
            // A block filled by exactly the last 8 bytes needs a separate pad block.
            padp_d      = (rem_after == '0) && (n == 3'd4);
            last_d      = (rem_after == '0) && (n != 3'd4);
          end
        end
      end
      EMIT: begin
        if (blk_ready) begin
          if (last_q)      state_d = IDLE;
          else if (padp_q) state_d = PAD;
          else begin
            buf_d   = '0;
            widx_d  = 1'b0;
            state_d = FILL;
          end
        end
      end
      PAD: begin
        if (blk_ready) begin
          state_d = IDLE;
          padp_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Set after the IDLE clear so a word arriving with load_length still flags overrun.
    if (load_data_in && state_q != FILL) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      widx_q  <= 1'b0;
      buf_q   <= '0;
      last_q  <= 1'b0;
      padp_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      widx_q  <= widx_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      padp_q  <= padp_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_ready = (state_q == FILL);
  assign blk_valid  = (state_q == EMIT) || (state_q == PAD);
  assign blk_data   = (state_q == PAD)  ? 64'h8000_0000_0000_0000 :
                      (state_q == EMIT) ? buf_q : '0;
  assign blk_last   = (state_q == PAD) || ((state_q == EMIT) && last_q);
  assign busy       = (state_q != IDLE);
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ascon_msg_loader.sv
// Directed bench for ascon_msg_loader: table of message transfers plus
// hand-written backpressure, overrun, empty-message and reset sequences.
module tb_ascon_msg_loader;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             load_length;
  logic [LEN_W-1:0] length_in;
  logic             load_data_in;
  logic [31:0]      data_in;
  logic             data_ready;
  logic             blk_valid;
  logic [63:0]      blk_data;
  logic             blk_last;
  logic             blk_ready;
  logic             busy;
  logic             overrun;

  ascon_msg_loader #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn),
    .load_length(load_length), .length_in(length_in),
    .load_data_in(load_data_in), .data_in(data_in), .data_ready(data_ready),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last), .blk_ready(blk_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LEN_W-1:0] len;
    int               nw;
    logic [31:0]      w[4];
    int               nb;
    logic [63:0]      bd[3];
    logic             bl[3];
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } blk_t;

  vec_t vecs[11];
  blk_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Record every block handshake; inputs change at posedge+1 so negedge is stable.
  always @(negedge clk) begin
    if (rstn && blk_valid && blk_ready) q.push_back('{d: blk_data, l: blk_last});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int idx, input logic [LEN_W-1:0] len, input int nw,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3, input int nb,
                         input logic [63:0] b0, input logic l0, input logic [63:0] b1,
                         input logic l1, input logic [63:0] b2, input logic l2);
    vecs[idx].len = len;  vecs[idx].nw = nw;
    vecs[idx].w[0] = w0;  vecs[idx].w[1] = w1; vecs[idx].w[2] = w2; vecs[idx].w[3] = w3;
    vecs[idx].nb = nb;
    vecs[idx].bd[0] = b0; vecs[idx].bl[0] = l0;
    vecs[idx].bd[1] = b1; vecs[idx].bl[1] = l1;
    vecs[idx].bd[2] = b2; vecs[idx].bl[2] = l2;
  endtask

  task automatic load_len(input logic [LEN_W-1:0] len);
    length_in = len;
    load_length = 1'b1;
    step();
    load_length = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int k = 0;
    while (!data_ready && k < 40) begin
      step();
      k++;
    end
    if (!data_ready) timeout("data_ready");
    else begin
      data_in = w;
      load_data_in = 1'b1;
      step();
      load_data_in = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 60) begin
      step();
      k++;
    end
    if (busy) timeout(name);
  endtask

  task automatic check_blocks(input string name, input vec_t v);
    chk({name, ".count"}, 64'(q.size()), 64'(v.nb));
    for (int i = 0; i < v.nb && i < q.size(); i++) begin
      chk($sformatf("%s.blk%0d.data", name, i), q[i].d, v.bd[i]);
      chk($sformatf("%s.blk%0d.last", name, i), 64'(q[i].l), 64'(v.bl[i]));
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    q.delete();
    blk_ready = 1'b1;
    load_len(v.len);
    for (int i = 0; i < v.nw; i++) send_word(v.w[i]);
    wait_idle(name);
    step();
    check_blocks(name, v);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, ".data_ready"}, 64'(data_ready), 64'd0);
    chk({name, ".blk_valid"},  64'(blk_valid),  64'd0);
    chk({name, ".blk_data"},   blk_data,        64'd0);
    chk({name, ".blk_last"},   64'(blk_last),   64'd0);
    chk({name, ".busy"},       64'(busy),       64'd0);
    chk({name, ".overrun"},    64'(overrun),    64'd0);
  endtask

  initial begin
    vec_t v;
    logic [63:0] pad = 64'h8000_0000_0000_0000;

    set_vec(0,  8,  2, 32'h01234567, 32'h89ABCDEF, 0, 0, 2, 64'h0123456789ABCDEF, 0, pad, 1, 0, 0);
    set_vec(1,  5,  2, 32'h11223344, 32'h55AABBCC, 0, 0, 1, 64'h1122334455800000, 1, 0, 0, 0, 0);
    set_vec(2,  0,  0, 0, 0, 0, 0,                      1, pad, 1, 0, 0, 0, 0);
    set_vec(3,  12, 3, 32'hA0A1A2A3, 32'hA4A5A6A7, 32'hA8A9AAAB, 0,
            2, 64'hA0A1A2A3A4A5A6A7, 0, 64'hA8A9AAAB80000000, 1, 0, 0);
    set_vec(4,  4,  1, 32'hDEADBEEF, 0, 0, 0,           1, 64'hDEADBEEF80000000, 1, 0, 0, 0, 0);
    set_vec(5,  3,  1, 32'hCAFEBABE, 0, 0, 0,           1, 64'hCAFEBA8000000000, 1, 0, 0, 0, 0);
    set_vec(6,  7,  2, 32'h01020304, 32'h05060708, 0, 0, 1, 64'h0102030405060780, 1, 0, 0, 0, 0);
    set_vec(7,  9,  3, 32'h11111111, 32'h22222222, 32'h33333333, 0,
            2, 64'h1111111122222222, 0, 64'h3380000000000000, 1, 0, 0);
    set_vec(8,  16, 4, 32'h10101010, 32'h20202020, 32'h30303030, 32'h40404040,
            3, 64'h1010101020202020, 0, 64'h3030303040404040, 0, pad, 1);
    set_vec(9,  1,  1, 32'hFF123456, 0, 0, 0,           1, 64'hFF80000000000000, 1, 0, 0, 0, 0);
    set_vec(10, 6,  2, 32'hAABBCCDD, 32'hEEFF1122, 0, 0, 1, 64'hAABBCCDDEEFF8000, 1, 0, 0, 0, 0);

    rstn = 1'b0; load_length = 1'b0; length_in = '0;
    load_data_in = 1'b0; data_in = '0; blk_ready = 1'b0;
    repeat (3) step();
    chk_outputs_zero("reset");
    rstn = 1'b1;
    step();

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Empty message: pad block straight away, data_ready stays low.
    q.delete();
    blk_ready = 1'b0;
    load_len(0);
    chk("len0.data_ready", 64'(data_ready), 64'd0);
    chk("len0.valid", 64'(blk_valid), 64'd1);
    chk("len0.data", blk_data, pad);
    chk("len0.last", 64'(blk_last), 64'd1);
    step();
    chk("len0.hold_data_ready", 64'(data_ready), 64'd0);
    chk("len0.hold_data", blk_data, pad);
    blk_ready = 1'b1;
    step();
    chk("len0.busy_after", 64'(busy), 64'd0);
    chk("len0.valid_after", 64'(blk_valid), 64'd0);

    // Backpressure on the first block of a 12-byte message.
    q.delete();
    blk_ready = 1'b0;
    load_len(12);
    send_word(32'hA0A1A2A3);
    send_word(32'hA4A5A6A7);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp.valid%0d", c), 64'(blk_valid), 64'd1);
      chk($sformatf("bp.data%0d", c), blk_data, 64'hA0A1A2A3A4A5A6A7);
      chk($sformatf("bp.last%0d", c), 64'(blk_last), 64'd0);
      chk($sformatf("bp.data_ready%0d", c), 64'(data_ready), 64'd0);
      step();
    end
    blk_ready = 1'b1;
    step();
    send_word(32'hA8A9AAAB);
    wait_idle("bp");
    step();
    check_blocks("bp", vecs[3]);

    // Word pushed during EMIT is dropped and flagged.
    q.delete();
    blk_ready = 1'b0;
    load_len(8);
    send_word(32'h01234567);
    send_word(32'h89ABCDEF);
    chk("ovr.pre", 64'(overrun), 64'd0);
    data_in = 32'hBAD0BAD0;
    load_data_in = 1'b1;
    step();
    load_data_in = 1'b0;
    chk("ovr.set", 64'(overrun), 64'd1);
    chk("ovr.data_held", blk_data, 64'h0123456789ABCDEF);
    blk_ready = 1'b1;
    wait_idle("ovr");
    step();
    check_blocks("ovr", vecs[0]);
    chk("ovr.sticky", 64'(overrun), 64'd1);
    q.delete();
    load_len(4);
    chk("ovr.cleared", 64'(overrun), 64'd0);
    send_word(32'hDEADBEEF);
    wait_idle("ovr2");
    step();
    check_blocks("ovr2", vecs[4]);

    // Length and data together in IDLE: length kept, word dropped.
    q.delete();
    length_in = 16'd4;
    data_in = 32'h55555555;
    load_length = 1'b1;
    load_data_in = 1'b1;
    step();
    load_length = 1'b0;
    load_data_in = 1'b0;
    chk("simul.overrun", 64'(overrun), 64'd1);
    chk("simul.data_ready", 64'(data_ready), 64'd1);
    send_word(32'h01020304);
    wait_idle("simul");
    step();
    chk("simul.count", 64'(q.size()), 64'd1);
    if (q.size() > 0) chk("simul.data", q[0].d, 64'h0102030480000000);

    // Reset in the middle of a block, then a fresh transfer.
    q.delete();
    load_len(8);
    send_word(32'h01234567);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk_outputs_zero("midrst");
    v = vecs[4];
    run_vec("postrst", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_msg_loader.md
Name: ascon_msg_loader

Overview:
- Upstream data stage for the ASCON core.
- Driven by the controller's load_length and load_data_in strobes; accepts the message length, then 32-bit message words.
- Assembles 64-bit rate blocks (ASCON-128, big-endian byte order), applies ASCON padding (0x80 byte then zeros), and hands blocks to the permutation datapath over a valid/ready handshake.

Parameters:
- LEN_W, 16, width of the message byte-length field (max message 2^LEN_W-1 bytes).

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- load_length  in  1  strobe from controller; captures length_in
- length_in  in  LEN_W  message length in bytes
- load_data_in  in  1  strobe from controller; captures data_in when data_ready=1
- data_in  in  32  message word; byte 0 in bits[31:24]
- data_ready  out  1  loader can accept a word this cycle
- blk_valid  out  1  blk_data/blk_last valid
- blk_data  out  64  rate block; first message byte in bits[63:56]
- blk_last  out  1  block is the final (padded) block
- blk_ready  in  1  downstream accepts block
- busy  out  1  high in any state but IDLE
- overrun  out  1  sticky: load_data_in seen while data_ready=0

Behaviour:
- Reset is synchronous: when rstn=0 at a clk edge, state=IDLE and all outputs, the buffer, the counters and the pad_pending flag are cleared. This applies mid-operation too; any partial block is discarded.
- FSM states: IDLE, FILL, EMIT, PAD.
- IDLE:
  - data_ready=0, blk_valid=0.
  - load_length: remaining<=length_in, word_idx<=0, buffer<=0, overrun<=0.
  - Next state is FILL if length_in!=0, else PAD.
- FILL:
  - data_ready=1.
  - On load_data_in: n=min(4,remaining) valid bytes. Bytes beyond n in the word are forced to 0.
  - If n<4, byte position n of the word gets 0x80.
  - The word is written to buffer bits[63:32] when word_idx=0, else to bits[31:0].
  - remaining-=n; word_idx toggles.
- FILL exit conditions:
  - word_idx=1 word accepted, or remaining becomes 0: go to EMIT next cycle.
  - remaining becomes 0 and the block holds <8 message bytes: blk_last=1. If the last word landed in the high half with n=4, the pad byte 0x80 goes to bits[31:24].
  - remaining becomes 0 and the block holds exactly 8 bytes: blk_last=0, pad_pending=1.
- EMIT:
  - blk_valid=1; blk_data and blk_last held stable until blk_ready=1.
  - On accept with blk_last=1: go to IDLE.
  - On accept with pad_pending=1: go to PAD.
  - Otherwise: clear buffer and word_idx, go to FILL.
- PAD:
  - blk_valid=1, blk_data=64'h8000_0000_0000_0000, blk_last=1.
  - On blk_ready: go to IDLE, clear pad_pending.
- Latency: the block-completing word is accepted at edge N; blk_valid=1 in the cycle after edge N. At most one block in flight; no skid buffer.
- load_data_in while data_ready=0 (IDLE/EMIT/PAD): the word is dropped and overrun<=1 (sticky until next load_length or reset).
- load_length outside IDLE is ignored.
- Simultaneous load_length and load_data_in in IDLE: length is captured, the data word is dropped, and overrun is set.
- busy=1 from the edge after load_length until the edge after the final block handshake.

Test Plan:
- len=8, words 0x01234567, 0x89ABCDEF, blk_ready=1 -> block 0x0123456789ABCDEF with last=0, then block 0x8000000000000000 with last=1; busy falls the next cycle.
- len=5, words 0x11223344, 0x55AABBCC -> single block 0x1122334455800000 with last=1 (trailing bytes masked).
- len=0 -> one block 0x8000000000000000 with last=1; data_ready never asserts.
- len=12, words 0xA0A1A2A3, 0xA4A5A6A7, 0xA8A9AAAB; blk_ready held low 3 cycles on the first block -> blk_data stable, data_ready=0 throughout; then 0xA0A1A2A3A4A5A6A7 with last=0, followed by 0xA8A9AAAB80000000 with last=1.
- load_data_in pulsed during EMIT -> overrun=1, word absent from the output; overrun clears on the next load_length.
- rstn=0 for one cycle mid-FILL (after 1 of 2 words) -> next cycle state IDLE, all outputs 0; a fresh len=4 transfer gives 0xDEADBEEF80000000 for word 0xDEADBEEF.
